// File: rtl/mode_timer_pkg.sv
// Shared types for the programmable event timer: run mode, count direction and FSM state.
package timer_pkg;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mode_timer_prescaler.sv
// Tick prescaler: emits one tick every PRESCALE enabled cycles; PRESCALE=1 reduces to tick = en.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = (pre_q == LAST) ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign tick = en && (pre_q == LAST);

endmodule

// File: rtl/mode_timer.sv
// Programmable up/down event timer with one-shot and periodic modes, terminal-count pulse
// and busy/done status.
//
// state | meaning
// IDLE  | stopped, count holds, ticks ignored
// RUN   | counting prescaled ticks toward the terminal value
// DONE  | one-shot reached its terminal value, count holds until start/stop
module mode_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    import timer_pkg::*;

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    dir_t             dir_q, dir_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             tick;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] next_cnt;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (start || stop),
        .en   (en && (state_q == RUN)),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        limit_d  = limit_q;
        count_d  = count_q;
        tc_d     = 1'b0;
        term     = (dir_q == DIR_DOWN) ? '0 : limit_q;
        reload   = (dir_q == DIR_DOWN) ? limit_q : '0;
        next_cnt = count_q;

        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            mode_d  = mode_t'(mode);
            dir_d   = dir_t'(dir);
            limit_d = limit;
            count_d = dir ? limit : '0;
            state_d = RUN;
            // start value already sits on the terminal value when limit is zero
            if (limit == '0) begin
                tc_d = 1'b1;
                if (mode_t'(mode) == MODE_ONESHOT) begin
                    state_d = DONE;
                end
            end
        end else if ((state_q == RUN) && tick) begin
            if (count_q == term) begin
                next_cnt = reload;
            end else if (dir_q == DIR_DOWN) begin
                next_cnt = count_q - WIDTH'(1);
            end else begin
                next_cnt = count_q + WIDTH'(1);
            end
            count_d = next_cnt;
            if (next_cnt == term) begin
                tc_d = 1'b1;
                if (mode_q == MODE_ONESHOT) begin
                    state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_ONESHOT;
            dir_q   <= DIR_UP;
            limit_q <= '0;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            limit_q <= limit_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_mode_timer.sv
// Self-checking bench: four timer instances (different PRESCALE/WIDTH) share stimulus and are
// compared every cycle against an elapsed-cycle arithmetic model, plus directed vectors.
module tb_mode_timer;

    logic       clk;
    logic       rst;
    logic       en;
    logic       start;
    logic       stop;
    logic       mode;
    logic       dir;
    logic [7:0] limit;

    logic [7:0] c0, c1, c2;
    logic [3:0] c3;
    logic [3:0] t_o, b_o, d_o;
    logic [7:0] cnt_o [4];

    mode_timer #(.WIDTH(8), .PRESCALE(1)) u_p1 (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .mode(mode), .dir(dir),
        .limit(limit), .count(c0), .tc(t_o[0]), .busy(b_o[0]), .done(d_o[0]));
    mode_timer #(.WIDTH(8), .PRESCALE(4)) u_p4 (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .mode(mode), .dir(dir),
        .limit(limit), .count(c1), .tc(t_o[1]), .busy(b_o[1]), .done(d_o[1]));
    mode_timer #(.WIDTH(8), .PRESCALE(2)) u_p2 (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .mode(mode), .dir(dir),
        .limit(limit), .count(c2), .tc(t_o[2]), .busy(b_o[2]), .done(d_o[2]));
    mode_timer #(.WIDTH(4), .PRESCALE(1)) u_w4 (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .mode(mode), .dir(dir),
        .limit(limit[3:0]), .count(c3), .tc(t_o[3]), .busy(b_o[3]), .done(d_o[3]));

    assign cnt_o[0] = c0;
    assign cnt_o[1] = c1;
    assign cnt_o[2] = c2;
    assign cnt_o[3] = {4'b0000, c3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model: phase 0 idle, 1 run, 2 done; e = enabled run cycles since start
    int P_OF [4] = '{1, 4, 2, 1};
    int LMASK[4] = '{255, 255, 255, 15};
    int m_phase[4];
    int m_e[4];
    int m_cnt[4];
    int m_lim[4];
    int m_mode[4];
    int m_dir[4];
    int m_tc[4];

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_phase[i] = 0; m_e[i] = 0; m_cnt[i] = 0; m_lim[i] = 0;
            m_mode[i] = 0; m_dir[i] = 0; m_tc[i] = 0;
        end
    endtask

    task automatic model_step();
        int n, k;
        for (int i = 0; i < 4; i++) begin
            m_tc[i] = 0;
            if (stop) begin
                m_phase[i] = 0;
            end else if (start) begin
                m_mode[i] = int'(mode);
                m_dir[i]  = int'(dir);
                m_lim[i]  = int'(limit) & LMASK[i];
                m_e[i]    = 0;
                m_cnt[i]  = m_dir[i] ? m_lim[i] : 0;
                m_tc[i]   = (m_lim[i] == 0) ? 1 : 0;
                m_phase[i] = (m_lim[i] == 0 && m_mode[i] == 0) ? 2 : 1;
            end else if (m_phase[i] == 1 && en) begin
                m_e[i]++;
                if (m_e[i] % P_OF[i] == 0) begin
                    n = m_e[i] / P_OF[i];
                    k = m_mode[i] ? (n % (m_lim[i] + 1)) : n;
                    m_cnt[i] = m_dir[i] ? (m_lim[i] - k) : k;
                    if (k == m_lim[i]) begin
                        m_tc[i] = 1;
                        if (m_mode[i] == 0) m_phase[i] = 2;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (int'(cnt_o[i]) !== m_cnt[i] || int'(t_o[i]) !== m_tc[i] ||
                int'(b_o[i]) !== int'(m_phase[i] == 1) || int'(d_o[i]) !== int'(m_phase[i] == 2)) begin
                n_err++;
                $display("FAIL model inst%0d: got cnt=%0d tc=%0d busy=%0d done=%0d expected cnt=%0d tc=%0d busy=%0d done=%0d",
                         i, cnt_o[i], t_o[i], b_o[i], d_o[i], m_cnt[i], m_tc[i],
                         int'(m_phase[i] == 1), int'(m_phase[i] == 2));
            end
        end
    endtask

    task automatic tick_cyc();
        @(posedge clk);
        model_step();
        #2;
        check_all();
    endtask

    task automatic async_rst();
        #1 rst = 1'b1;
        #1 model_reset();
        chk("rst count", int'(c0), 0);
        chk("rst busy", int'(b_o), 0);
        chk("rst done", int'(d_o), 0);
        chk("rst tc", int'(t_o), 0);
        check_all();
        #1 rst = 1'b0;
    endtask

    task automatic set_in(input bit st, input bit sp, input bit e, input bit md, input bit dr,
                          input int lim);
        start = st; stop = sp; en = e; mode = md; dir = dr; limit = 8'(lim);
    endtask

    typedef struct {
        bit st, sp, en, md, dr;
        int lim;
        int c, t, b, d;
    } vec_t;

    vec_t vecs[19];
    int done_at;

    initial begin
        vecs[0]  = '{1, 0, 1, 0, 0, 3, 0, 0, 1, 0};
        vecs[1]  = '{0, 0, 1, 0, 0, 3, 1, 0, 1, 0};
        vecs[2]  = '{0, 0, 1, 0, 0, 3, 2, 0, 1, 0};
        vecs[3]  = '{0, 0, 1, 0, 0, 3, 3, 1, 0, 1};
        vecs[4]  = '{0, 0, 1, 0, 0, 3, 3, 0, 0, 1};
        vecs[5]  = '{1, 0, 1, 0, 0, 0, 0, 1, 0, 1};
        vecs[6]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        vecs[7]  = '{1, 0, 1, 1, 0, 0, 0, 1, 1, 0};
        vecs[8]  = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
        vecs[9]  = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
        vecs[10] = '{1, 0, 1, 1, 0, 5, 0, 0, 1, 0};
        vecs[11] = '{0, 0, 1, 1, 0, 5, 1, 0, 1, 0};
        vecs[12] = '{0, 0, 1, 1, 0, 5, 2, 0, 1, 0};
        vecs[13] = '{1, 1, 1, 1, 0, 9, 2, 0, 0, 0};
        vecs[14] = '{0, 0, 1, 1, 0, 9, 2, 0, 0, 0};
        vecs[15] = '{1, 0, 1, 0, 1, 2, 2, 0, 1, 0};
        vecs[16] = '{0, 0, 1, 0, 1, 2, 1, 0, 1, 0};
        vecs[17] = '{0, 0, 1, 0, 1, 2, 0, 1, 0, 1};
        vecs[18] = '{1, 0, 1, 0, 0, 4, 0, 0, 1, 0};

        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        #2 model_reset();
        chk("reset count", int'(c0), 0);
        chk("reset flags", int'({t_o, b_o, d_o}), 0);
        check_all();
        #20 rst = 1'b0;

        // table vectors, expectations for the PRESCALE=1 instance
        for (int v = 0; v < 19; v++) begin
            set_in(vecs[v].st, vecs[v].sp, vecs[v].en, vecs[v].md, vecs[v].dr, vecs[v].lim);
            tick_cyc();
            chk($sformatf("vec%0d count", v), int'(c0), vecs[v].c);
            chk($sformatf("vec%0d tc", v), int'(t_o[0]), vecs[v].t);
            chk($sformatf("vec%0d busy", v), int'(b_o[0]), vecs[v].b);
            chk($sformatf("vec%0d done", v), int'(d_o[0]), vecs[v].d);
        end

        // one-shot up holds at its limit long after finishing
        set_in(1, 0, 1, 0, 0, 3);
        tick_cyc();
        start = 1'b0;
        for (int k = 0; k < 13; k++) tick_cyc();
        chk("oneshot hold count", int'(c0), 3);
        chk("oneshot hold done", int'(d_o[0]), 1);

        // periodic down, PRESCALE=4, limit 2
        set_in(1, 0, 1, 1, 1, 2);
        tick_cyc();
        start = 1'b0;
        chk("pdown start", int'(c1), 2);
        for (int k = 1; k <= 36; k++) begin
            tick_cyc();
            chk($sformatf("pdown count k%0d", k), int'(c1), 2 - ((k / 4) % 3));
            chk($sformatf("pdown tc k%0d", k), int'(t_o[1]),
                int'((k % 4 == 0) && ((k / 4) % 3 == 2)));
        end

        // enable gating and ignored limit change, PRESCALE=2 one-shot up limit 5
        set_in(1, 0, 1, 0, 0, 5);
        tick_cyc();
        start = 1'b0;
        done_at = -1;
        for (int k = 1; k <= 40; k++) begin
            en = !(k >= 4 && k <= 10);
            if (k == 2) limit = 8'd1;
            tick_cyc();
            if (done_at < 0 && d_o[2]) done_at = k;
        end
        chk("gated done edge", done_at, 17);
        chk("gated final count", int'(c2), 5);

        // 4-bit periodic up at full-scale limit
        set_in(1, 0, 1, 1, 0, 15);
        tick_cyc();
        start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick_cyc();
            if (k == 15) begin
                chk("w4 top count", int'(c3), 15);
                chk("w4 top tc", int'(t_o[3]), 1);
            end
            if (k == 16) begin
                chk("w4 reload count", int'(c3), 0);
                chk("w4 reload tc", int'(t_o[3]), 0);
            end
            if (k == 17) chk("w4 step count", int'(c3), 1);
        end

        // asynchronous reset mid-run, then stays idle
        set_in(1, 0, 1, 0, 0, 10);
        tick_cyc();
        start = 1'b0;
        for (int k = 0; k < 3; k++) tick_cyc();
        chk("pre-rst count", int'(c0), 3);
        async_rst();
        for (int k = 0; k < 5; k++) tick_cyc();
        chk("post-rst idle count", int'(c0), 0);
        chk("post-rst idle busy", int'(b_o[0]), 0);

        // randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            start = ($urandom % 16) == 0;
            stop  = ($urandom % 40) == 0;
            en    = ($urandom % 4) != 0;
            mode  = 1'($urandom);
            dir   = 1'($urandom);
            limit = (($urandom % 8) == 0) ? 8'($urandom) : 8'($urandom % 12);
            tick_cyc();
            if (($urandom % 700) == 0) async_rst();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
